// File: rtl/cfg_writer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cfg_writer_pkg
// Brief    : Shared state codes, CRC constants and widths for cfg_word_writer.
// Revision : 1.0
// ============================================================================
package cfg_writer_pkg;

    localparam int BYTE_IDX_W = 2;
    localparam int WORD_CNT_W = 16;
    localparam int STATE_W    = 3;
    localparam int TMR_W      = 16;

    localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
    localparam logic [STATE_W-1:0] ST_COLLECT = 3'd1;
    localparam logic [STATE_W-1:0] ST_SETUP   = 3'd2;
    localparam logic [STATE_W-1:0] ST_STROBE  = 3'd3;
    localparam logic [STATE_W-1:0] ST_HOLD    = 3'd4;
    localparam logic [STATE_W-1:0] ST_CRC_RX  = 3'd5;
    localparam logic [STATE_W-1:0] ST_DONE    = 3'd6;
    localparam logic [STATE_W-1:0] ST_ERR     = 3'd7;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

endpackage
`default_nettype wire

// File: rtl/crc16_ccitt_byte.sv
`default_nettype none
// ============================================================================
// Module   : crc16_ccitt_byte
// Brief    : Combinational CRC-16/CCITT-FALSE next value for one byte, MSB first.
//            Present only when SAUBER_CFG_CRC_EN is defined.
// Revision : 1.0
// ============================================================================
`ifdef SAUBER_CFG_CRC_EN
module crc16_ccitt_byte
    import cfg_writer_pkg::*;
(
    input  logic [15:0] crc_i,
    input  logic [7:0]  data_i,
    output logic [15:0] crc_o
);

    logic [15:0] c;

    always_comb begin
        c = crc_i ^ {data_i, 8'h00};
        for (int i = 0; i < 8; i++) begin
            c = c[15] ? ((c << 1) ^ CRC_POLY) : (c << 1);
        end
        crc_o = c;
    end

endmodule
`endif
`default_nettype wire

// File: rtl/cfg_word_writer.sv
`default_nettype none
// ============================================================================
// Module   : cfg_word_writer
// Brief    : Packs a byte stream big-endian into 32-bit words and drives the
//            self-write port with setup/strobe/hold spacing. Optional trailing
//            CRC check is enabled by SAUBER_CFG_CRC_EN.
// Revision : 1.0
// ============================================================================
module cfg_word_writer
    import cfg_writer_pkg::*;
#(
    parameter int NUM_BYTES = 21140,
    parameter int SETUP_CYC = 2,
    parameter int HOLD_CYC  = 2
)
(
    input  logic        CLK,
    input  logic        rst_sync_cfg,
    input  logic        start,
    input  logic [7:0]  byte_data,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic [31:0] SelfWriteData,
    output logic        SelfWriteStrobe,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] word_cnt
);

    if (NUM_BYTES <= 0 || (NUM_BYTES % 4) != 0) begin : g_chk_num_bytes
        $error("cfg_word_writer: NUM_BYTES must be a nonzero multiple of 4");
    end
    if ((NUM_BYTES / 4) > 65535) begin : g_chk_word_cnt
        $error("cfg_word_writer: NUM_BYTES/4 must fit in 16 bits");
    end
    if (SETUP_CYC < 1 || SETUP_CYC > 65536) begin : g_chk_setup
        $error("cfg_word_writer: SETUP_CYC out of range");
    end
    if (HOLD_CYC < 1 || HOLD_CYC > 65536) begin : g_chk_hold
        $error("cfg_word_writer: HOLD_CYC out of range");
    end

    localparam logic [WORD_CNT_W-1:0] NUM_WORDS  = WORD_CNT_W'(NUM_BYTES / 4);
    localparam logic [TMR_W-1:0]      SETUP_LAST = TMR_W'(SETUP_CYC - 1);
    localparam logic [TMR_W-1:0]      HOLD_LAST  = TMR_W'(HOLD_CYC - 1);

    logic [STATE_W-1:0]    state_q,    state_d;
    logic [BYTE_IDX_W-1:0] byte_idx_q, byte_idx_d;
    logic [23:0]           pack_q,     pack_d;
    logic [31:0]           data_q,     data_d;
    logic [WORD_CNT_W-1:0] word_cnt_q, word_cnt_d;
    logic [TMR_W-1:0]      tmr_q,      tmr_d;

    logic w_accept;
    logic w_session_start;

    assign w_accept        = byte_valid && byte_ready;
    assign w_session_start = start && ((state_q == ST_IDLE) || (state_q == ST_DONE) ||
                                       (state_q == ST_ERR));

`ifdef SAUBER_CFG_CRC_EN
    logic [15:0] crc_q, crc_d;
    logic [15:0] w_crc_next;

    crc16_ccitt_byte u_crc (
        .crc_i  (crc_q),
        .data_i (byte_data),
        .crc_o  (w_crc_next)
    );

    // Only payload bytes feed the CRC; the two trailing CRC bytes do not.
    always_comb begin
        crc_d = crc_q;
        if (w_session_start) begin
            crc_d = CRC_INIT;
        end else if (state_q == ST_COLLECT && w_accept) begin
            crc_d = w_crc_next;
        end
    end

    always_ff @(posedge CLK) begin
        if (rst_sync_cfg) begin
            crc_q <= CRC_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end
`endif

    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        pack_d     = pack_q;
        data_d     = data_q;
        word_cnt_d = word_cnt_q;
        tmr_d      = tmr_q;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (w_session_start) begin
                    state_d    = ST_COLLECT;
                    byte_idx_d = '0;
                    word_cnt_d = '0;
                end
            end
            ST_COLLECT: begin
                if (w_accept) begin
                    if (byte_idx_q == 2'd3) begin
                        data_d     = {pack_q, byte_data};
                        byte_idx_d = '0;
                        tmr_d      = '0;
                        state_d    = ST_SETUP;
                    end else begin
                        pack_d     = {pack_q[15:0], byte_data};
                        byte_idx_d = byte_idx_q + 2'd1;
                    end
                end
            end
            ST_SETUP: begin
                if (tmr_q == SETUP_LAST) begin
                    tmr_d   = '0;
                    state_d = ST_STROBE;
                end else begin
                    tmr_d = tmr_q + 16'd1;
                end
            end
            ST_STROBE: begin
                word_cnt_d = word_cnt_q + 16'd1;
                tmr_d      = '0;
                state_d    = ST_HOLD;
            end
            ST_HOLD: begin
                if (tmr_q == HOLD_LAST) begin
                    tmr_d = '0;
                    if (word_cnt_q == NUM_WORDS) begin
`ifdef SAUBER_CFG_CRC_EN
                        state_d = ST_CRC_RX;
`else
                        state_d = ST_DONE;
`endif
                    end else begin
                        state_d = ST_COLLECT;
                    end
                end else begin
                    tmr_d = tmr_q + 16'd1;
                end
            end
`ifdef SAUBER_CFG_CRC_EN
            // First received CRC byte is parked in the low pack byte.
            ST_CRC_RX: begin
                if (w_accept) begin
                    if (byte_idx_q == 2'd0) begin
                        pack_d[7:0] = byte_data;
                        byte_idx_d  = 2'd1;
                    end else begin
                        byte_idx_d = '0;
                        state_d    = ({pack_q[7:0], byte_data} == crc_q) ? ST_DONE : ST_ERR;
                    end
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (rst_sync_cfg) begin
            state_q    <= ST_IDLE;
            byte_idx_q <= '0;
            pack_q     <= '0;
            data_q     <= '0;
            word_cnt_q <= '0;
            tmr_q      <= '0;
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            pack_q     <= pack_d;
            data_q     <= data_d;
            word_cnt_q <= word_cnt_d;
            tmr_q      <= tmr_d;
        end
    end

    assign SelfWriteData   = data_q;
    assign SelfWriteStrobe = (state_q == ST_STROBE);
    assign done            = (state_q == ST_DONE);
    assign word_cnt        = word_cnt_q;

`ifdef SAUBER_CFG_CRC_EN
    assign byte_ready = (state_q == ST_COLLECT) || (state_q == ST_CRC_RX);
    assign busy       = (state_q == ST_COLLECT) || (state_q == ST_SETUP) ||
                        (state_q == ST_STROBE)  || (state_q == ST_HOLD)  ||
                        (state_q == ST_CRC_RX);
    assign err        = (state_q == ST_ERR);
`else
    assign byte_ready = (state_q == ST_COLLECT);
    assign busy       = (state_q == ST_COLLECT) || (state_q == ST_SETUP) ||
                        (state_q == ST_STROBE)  || (state_q == ST_HOLD);
    assign err        = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cfg_word_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cfg_word_writer
// Brief    : Scoreboard bench for cfg_word_writer (8-byte and 4-byte instances).
// Revision : 1.0
// ============================================================================
module tb_cfg_word_writer;

    logic        CLK = 1'b0;
    logic        rst;
    logic        st[2];
    logic        bv[2];
    logic [7:0]  bd[2];
    logic        rdy[2], sws[2], bsy[2], dn[2], er[2];
    logic [31:0] swd[2];
    logic [15:0] wc[2];

    always #5 CLK = ~CLK;

    cfg_word_writer #(.NUM_BYTES(8), .SETUP_CYC(2), .HOLD_CYC(2)) dut (
        .CLK(CLK), .rst_sync_cfg(rst), .start(st[0]), .byte_data(bd[0]),
        .byte_valid(bv[0]), .byte_ready(rdy[0]), .SelfWriteData(swd[0]),
        .SelfWriteStrobe(sws[0]), .busy(bsy[0]), .done(dn[0]), .err(er[0]),
        .word_cnt(wc[0])
    );

    cfg_word_writer #(.NUM_BYTES(4), .SETUP_CYC(2), .HOLD_CYC(2)) dut4 (
        .CLK(CLK), .rst_sync_cfg(rst), .start(st[1]), .byte_data(bd[1]),
        .byte_valid(bv[1]), .byte_ready(rdy[1]), .SelfWriteData(swd[1]),
        .SelfWriteStrobe(sws[1]), .busy(bsy[1]), .done(dn[1]), .err(er[1]),
        .word_cnt(wc[1])
    );

    typedef struct {
        logic [31:0] w;
        logic [15:0] cnt;
        bit          last;
    } exp_t;

    int          checks = 0;
    int          errors = 0;
    exp_t        q0[$];
    exp_t        q1[$];
    logic [7:0]  stim[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, expv, $time);
        end
    endtask

    function automatic logic [15:0] crc_model(input int n);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            for (int b = 7; b >= 0; b--) begin
                fb = c[15] ^ stim[i][b];
                c  = {c[14:0], 1'b0};
                if (fb) c = c ^ 16'h1021;
            end
        end
        return c;
    endfunction

    // Monitor: pops the scoreboard on every strobe and checks the spacing window.
    int          post[2];
    exp_t        cur[2];
    exp_t        e;
    logic [31:0] d1[2], d2[2];
    logic        r1[2], r2[2], s1[2];

    initial begin
        for (int k = 0; k < 2; k++) begin
            post[k] = 0; d1[k] = '0; d2[k] = '0; r1[k] = 0; r2[k] = 0; s1[k] = 0;
        end
    end

    always @(negedge CLK) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) post[k] = 0;
            if (sws[k]) begin
                chk("strobe_width", {31'b0, s1[k]}, 32'd0);
                if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe: dut%0d strobed 0x%0h with no word expected at %0t",
                             k, swd[k], $time);
                end else begin
                    if (k == 0) e = q0.pop_front();
                    else        e = q1.pop_front();
                    cur[k] = e;
                    chk("strobe_word", swd[k], e.w);
                    chk("setup_data_m1", d1[k], e.w);
                    chk("setup_data_m2", d2[k], e.w);
                    chk("setup_ready", {30'b0, r1[k], r2[k]}, 32'd0);
                    post[k] = 1;
                end
            end else if (post[k] > 0) begin
                if (post[k] < 3) begin
                    chk("hold_data", swd[k], cur[k].w);
                    chk("hold_ready", {31'b0, rdy[k]}, 32'd0);
                    if (post[k] == 1) chk("word_cnt", {16'b0, wc[k]}, {16'b0, cur[k].cnt});
                    post[k]++;
                end else begin
`ifdef SAUBER_CFG_CRC_EN
                    chk("after_hold_ready", {31'b0, rdy[k]}, 32'd1);
                    chk("after_hold_done", {31'b0, dn[k]}, 32'd0);
`else
                    chk("after_hold_ready", {31'b0, rdy[k]}, {31'b0, !cur[k].last});
                    chk("after_hold_done", {31'b0, dn[k]}, {31'b0, cur[k].last});
`endif
                    post[k] = 0;
                end
            end
            d2[k] = d1[k]; d1[k] = swd[k];
            r2[k] = r1[k]; r1[k] = rdy[k];
            s1[k] = sws[k];
        end
    end

    task automatic send_byte(input int sel, input logic [7:0] b, input bit gaps);
        int t;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                bv[sel] = 1'b0;
                @(negedge CLK);
            end
        end
        bv[sel] = 1'b1;
        bd[sel] = b;
        t = 0;
        while (!rdy[sel] && t < 50) begin
            @(negedge CLK);
            t++;
        end
        if (!rdy[sel]) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: dut%0d byte_ready stayed 0, expected 1", sel);
        end
        @(negedge CLK);
    endtask

    task automatic run_session(input int sel, input bit gaps, input bit flip, input bit hold_start);
        int          n;
        int          t;
        bit          fe;
        logic [15:0] c;
        exp_t        x;
        n  = stim.size();
        fe = flip;
`ifndef SAUBER_CFG_CRC_EN
        fe = 1'b0;
`endif
        for (int w = 0; w < n / 4; w++) begin
            x.w    = {stim[4*w], stim[4*w+1], stim[4*w+2], stim[4*w+3]};
            x.cnt  = 16'(w + 1);
            x.last = (w == n / 4 - 1);
            if (sel == 0) q0.push_back(x);
            else          q1.push_back(x);
        end
        st[sel] = 1'b1;
        @(negedge CLK);
        st[sel] = 1'b0;
        chk("start_word_cnt", {16'b0, wc[sel]}, 32'd0);
        chk("start_done", {31'b0, dn[sel]}, 32'd0);
        chk("start_err", {31'b0, er[sel]}, 32'd0);
        chk("start_busy", {31'b0, bsy[sel]}, 32'd1);
        for (int i = 0; i < n; i++) begin
            if (hold_start && i == 4) begin
                t = 0;
                while (!sws[sel] && t < 20) begin
                    @(negedge CLK);
                    t++;
                end
                chk("hold_start_saw_strobe", {31'b0, sws[sel]}, 32'd1);
                @(negedge CLK);
                st[sel] = 1'b1;
                @(negedge CLK);
                @(negedge CLK);
                st[sel] = 1'b0;
            end
            send_byte(sel, stim[i], gaps);
        end
`ifdef SAUBER_CFG_CRC_EN
        c = crc_model(n) ^ {15'b0, fe};
        send_byte(sel, c[15:8], gaps);
        send_byte(sel, c[7:0], gaps);
`else
        c = 16'h0;
`endif
        bv[sel] = 1'b0;
        t = 0;
        while (!dn[sel] && !er[sel] && t < 60) begin
            @(negedge CLK);
            t++;
        end
        chk("end_done", {31'b0, dn[sel]}, {31'b0, !fe});
        chk("end_err", {31'b0, er[sel]}, {31'b0, fe});
        chk("end_word_cnt", {16'b0, wc[sel]}, 32'(n / 4));
        chk("end_busy", {31'b0, bsy[sel]}, 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            st[k] = 1'b0; bv[k] = 1'b0; bd[k] = 8'h00;
        end
        repeat (3) @(negedge CLK);
        for (int k = 0; k < 2; k++) begin
            chk("rst_flags", {27'b0, sws[k], bsy[k], dn[k], er[k], rdy[k]}, 32'd0);
            chk("rst_data", swd[k], 32'd0);
            chk("rst_word_cnt", {16'b0, wc[k]}, 32'd0);
        end
        rst = 1'b0;
        @(negedge CLK);

        // Back-to-back bytes.
        stim = '{8'hFA, 8'hB0, 8'hFA, 8'hB1, 8'h00, 8'h00, 8'h00, 8'h01};
        run_session(0, 1'b0, 1'b0, 1'b0);

        // Same bytes with random valid gaps; CRC corrupted when the check exists.
        run_session(0, 1'b1, 1'b1, 1'b0);

        // start held during HOLD of the first word must be ignored.
        stim = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        run_session(0, 1'b0, 1'b0, 1'b1);

        // Reset mid-word discards the partial word.
        st[0] = 1'b1;
        @(negedge CLK);
        st[0] = 1'b0;
        send_byte(0, 8'hAA, 1'b0);
        send_byte(0, 8'hBB, 1'b0);
        bv[0] = 1'b0;
        rst   = 1'b1;
        @(negedge CLK);
        chk("midrst_flags", {27'b0, sws[0], bsy[0], dn[0], er[0], rdy[0]}, 32'd0);
        chk("midrst_data", swd[0], 32'd0);
        chk("midrst_word_cnt", {16'b0, wc[0]}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge CLK);
        stim = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        run_session(0, 1'b0, 1'b0, 1'b0);

        // Single-word instance.
        stim = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        run_session(1, 1'b0, 1'b0, 1'b0);
        bv[1] = 1'b1;
        bd[1] = 8'h5A;
        repeat (5) begin
            @(negedge CLK);
            chk("no_ready_after_done", {31'b0, rdy[1]}, 32'd0);
            chk("done_sticky", {31'b0, dn[1]}, 32'd1);
        end
        bv[1] = 1'b0;

        repeat (5) @(negedge CLK);
        chk("scoreboard_drained", 32'(q0.size() + q1.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cfg_word_writer.md
# cfg_word_writer

Configuration-stream front end that sits directly upstream of the fabric's self-write configuration port. It accepts the bitstream one byte per handshake, packs four bytes big-endian into a 32-bit word, and drives SelfWriteData/SelfWriteStrobe with fixed setup and hold spacing around a one-cycle strobe. It counts words, reports completion, and can optionally check a trailing CRC before the fabric is released from rst_sync_fabric.

## Interface
- NUM_BYTES, 21140, bitstream length in bytes; must be a nonzero multiple of 4 (elaboration-time error otherwise)
- SETUP_CYC, 2, cycles SelfWriteData is stable before the strobe; ≥1
- HOLD_CYC, 2, cycles SelfWriteData is held after the strobe; ≥1
- CLK  in  1  single clock, rising edge
- rst_sync_cfg  in  1  synchronous, active-high reset
- start  in  1  begins a load session; level is sampled, but it acts only in IDLE, DONE or ERR
- byte_data  in  8  bitstream byte
- byte_valid  in  1  byte_data is valid
- byte_ready  out  1  block accepts a byte this cycle
- SelfWriteData  out  32  packed configuration word
- SelfWriteStrobe  out  1  one-cycle write pulse
- busy  out  1  session in progress
- done  out  1  session completed successfully; sticky until start or reset
- err  out  1  CRC mismatch; sticky until start or reset
- word_cnt  out  16  number of words strobed in this session

## Operation
- Reset: state IDLE. All outputs 0, including SelfWriteData. Byte index, word_cnt and CRC are cleared.
- Byte transfer: a byte is accepted on a rising edge when byte_valid && byte_ready.
- States and transitions:
  - IDLE: start → COLLECT.
  - COLLECT: byte_ready=1. Accepts bytes b0..b3. On acceptance of b3, SelfWriteData ← {b0,b1,b2,b3} → SETUP.
  - SETUP: lasts SETUP_CYC cycles → STROBE.
  - STROBE: SelfWriteStrobe=1 for exactly 1 cycle; word_cnt increments at its end → HOLD.
  - HOLD: lasts HOLD_CYC cycles. Then, if word_cnt == NUM_BYTES/4 → DONE (or CRC_RX with the macro); otherwise → COLLECT.
  - DONE: done=1, busy=0.
  - ERR: err=1, busy=0.
- busy=1 in COLLECT, SETUP, STROBE, HOLD and CRC_RX.
- byte_ready=0 outside COLLECT and CRC_RX; bytes presented then are simply not taken.
- SelfWriteData keeps the last word after HOLD and changes only when a new word is packed.
- start while busy: ignored.
- start in DONE or ERR: clears word_cnt, byte index, CRC, done and err → COLLECT.
- rst_sync_cfg asserted in any state, mid-word or mid-strobe: all outputs are 0 from the next edge and a partial word is discarded. The next session begins at b0.
- word_cnt is 16 bits and never wraps, because NUM_BYTES/4 ≤ 65535 is checked at elaboration.

## Timing
- b3 accepted at edge N: SelfWriteData is valid from cycle N+1. The strobe is high in cycle N+1+SETUP_CYC. byte_ready returns in cycle N+2+SETUP_CYC+HOLD_CYC.
- Minimum period per word: 4+SETUP_CYC+1+HOLD_CYC cycles, which is 9 at the defaults.
- Without the CRC macro, done rises one cycle after the last HOLD cycle.

## Configuration
- SAUBER_CFG_CRC_EN defined:
  - A CRC-16/CCITT-FALSE (poly 0x1021, init 0xFFFF, no reflection, no final XOR) is updated on every accepted payload byte.
  - After the last HOLD, state CRC_RX accepts 2 more bytes, MSB first.
  - Match → DONE; mismatch → ERR.
  - Words already strobed are not undone; err tells the system to keep rst_sync_fabric asserted.
- SAUBER_CFG_CRC_EN undefined: no CRC logic and no CRC_RX state; err is tied to 0.

## Structure
- Package cfg_writer_pkg holds:
  - the state enum (IDLE, COLLECT, SETUP, STROBE, HOLD, CRC_RX, DONE, ERR);
  - CRC_POLY = 16'h1021 and CRC_INIT = 16'hFFFF;
  - the byte-index and word-count widths.
- Sub-module crc16_ccitt_byte: combinational next-CRC from (crc, byte). It is instantiated only under SAUBER_CFG_CRC_EN.

## Test plan
- NUM_BYTES=8, bytes FA B0 FA B1 00 00 00 01 with byte_valid held high → strobe 1 carries 0xFAB0FAB1, strobe 2 carries 0x00000001. Each strobe is exactly 1 cycle, with data stable 2 cycles before and 2 cycles after. word_cnt=2, then done=1.
- Random byte_valid gaps, same 8 bytes → identical words and strobe spacing; byte_ready=0 throughout SETUP, STROBE and HOLD.
- With the macro, send the model CRC → done=1, err=0. Resend with CRC^16'h0001 → err=1, done=0, and 2 words still strobed.
- Reset after 2 bytes of word 0, then start and send 4 fresh bytes 11 22 33 44 → the first strobed word is 0x11223344; no strobe occurs during or right after reset.
- start pulsed during HOLD → ignored. start after done → word_cnt=0 and done=0 next cycle, and a new session completes.
- NUM_BYTES=4, single word 0xDEADBEEF → exactly one strobe, word_cnt=1, done=1, and no further byte_ready.
